fifo_pkt: RTL and testbench

Single-clock, parametrised FIFO with optional packet commit/discard semantics, generalising the existing small Gray-coded CDC FIFO to arbitrary width and depth with level reporting.
Sits in the capture path after clock-domain crossing, before the USB transfer engine.
- Buffers captured packet bytes.
- Drops whole packets cleanly on overflow or on an upstream error, so that no partial packet ever reaches the reader.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_pkt_mem.sv | 27 ++
 rtl/fifo_pkt.sv | 131 +++++++++++++
 tb/tb_fifo_pkt.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: write-side FSM encoding and pointer arithmetic.
`timescale 1ns/1ps
package fifo_pkg;

  typedef enum logic {
    ST_NORMAL,
    ST_DROPPING
  } fifo_state_e;

  // Difference of two wrap-bit pointers, taken modulo 2**ptr_w.
  function automatic int unsigned ptr_diff(input int unsigned a, input int unsigned b,
                                           input int unsigned ptr_w);
    return (a - b) & ((32'd1 << ptr_w) - 32'd1);
  endfunction

endpackage

// File: rtl/fifo_pkt_mem.sv
// W x DEPTH storage: synchronous write, asynchronous read (distributed RAM style).
`timescale 1ns/1ps
module fifo_pkt_mem #(
  parameter int unsigned W          = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [DEPTH_LOG2-1:0] wr_addr_i,
  input  logic [W-1:0]          wr_data_i,
  input  logic [DEPTH_LOG2-1:0] rd_addr_i,
  output logic [W-1:0]          rd_data_o
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [W-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fifo_pkt.sv
// Single-clock FIFO with optional packet commit/discard; overflowing packets are dropped whole.
`timescale 1ns/1ps
module fifo_pkt
  import fifo_pkg::*;
#(
  parameter int unsigned W          = 8,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned PKT_MODE   = 1,
  parameter int unsigned AF_LEVEL   = 12
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [W-1:0]          wr_data_i,
  input  logic                  wr_en_i,
  input  logic                  wr_commit_i,
  input  logic                  wr_discard_i,
  output logic                  wr_ready_o,
  output logic                  drop_o,
  output logic [W-1:0]          rd_data_o,
  input  logic                  rd_en_i,
  output logic                  rd_valid_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  almost_full_o
);

  localparam int unsigned PtrW  = DEPTH_LOG2 + 1;
  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] cmt_ptr_q, cmt_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  fifo_state_e     state_q, state_d;
  logic            drop_q, drop_d;
  logic            mem_we;
  logic [PtrW-1:0] used_cnt;
  logic            full;
  logic            rd_pop;

  // used_cnt includes uncommitted entries; level_o counts only committed ones.
  assign used_cnt      = PtrW'(ptr_diff(32'(wr_ptr_q), 32'(rd_ptr_q), PtrW));
  assign full          = (used_cnt == PtrW'(Depth));
  assign wr_ready_o    = !full;
  assign rd_valid_o    = (rd_ptr_q != cmt_ptr_q);
  assign rd_pop        = rd_en_i && rd_valid_o;
  assign level_o       = PtrW'(ptr_diff(32'(cmt_ptr_q), 32'(rd_ptr_q), PtrW));
  assign almost_full_o = (used_cnt >= PtrW'(AF_LEVEL));
  assign drop_o        = drop_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    state_d   = state_q;
    drop_d    = 1'b0;
    mem_we    = 1'b0;
    rd_ptr_d  = rd_ptr_q + PtrW'(rd_pop);

    if (PKT_MODE == 0) begin
      if (wr_en_i) begin
        if (full) begin
          drop_d = 1'b1;
        end else begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
      end
      cmt_ptr_d = wr_ptr_d;
      state_d   = ST_NORMAL;
    end else begin
      case (state_q)
        ST_NORMAL: begin
          if (wr_discard_i) begin
            wr_ptr_d = cmt_ptr_q;
          end else if (wr_en_i && full) begin
            // Overflow on the closing beat drops the packet without entering DROPPING.
            if (wr_commit_i) begin
              wr_ptr_d = cmt_ptr_q;
              drop_d   = 1'b1;
            end else begin
              state_d = ST_DROPPING;
            end
          end else begin
            if (wr_en_i) begin
              mem_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (wr_commit_i) begin
              cmt_ptr_d = wr_ptr_d;
            end
          end
        end
        ST_DROPPING: begin
          if (wr_commit_i || wr_discard_i) begin
            wr_ptr_d = cmt_ptr_q;
            drop_d   = 1'b1;
            state_d  = ST_NORMAL;
          end
        end
        default: state_d = ST_NORMAL;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q  <= '0;
      cmt_ptr_q <= '0;
      rd_ptr_q  <= '0;
      state_q   <= ST_NORMAL;
      drop_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      cmt_ptr_q <= cmt_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      state_q   <= state_d;
      drop_q    <= drop_d;
    end
  end

  fifo_pkt_mem #(
    .W          (W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk_i     (clk_i),
    .wr_en_i   (mem_we),
    .wr_addr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
    .wr_data_i (wr_data_i),
    .rd_addr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
    .rd_data_o (rd_data_o)
  );

endmodule

// File: tb/tb_fifo_pkt.sv
// Bench for fifo_pkt: a streaming (PKT_MODE=0) and a packet (PKT_MODE=1) instance vs queue models.
`timescale 1ns/1ps
module tb_fifo_pkt;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] s_wr_data = '0, p_wr_data = '0;
  logic s_wr_en = 0, s_commit = 0, s_discard = 0, s_rd_en = 0;
  logic p_wr_en = 0, p_commit = 0, p_discard = 0, p_rd_en = 0;
  logic s_wr_ready, s_drop, s_rd_valid, s_af;
  logic p_wr_ready, p_drop, p_rd_valid, p_af;
  logic [7:0] s_rd_data, p_rd_data;
  logic [4:0] s_level, p_level;

  fifo_pkt #(.W(8), .DEPTH_LOG2(4), .PKT_MODE(0), .AF_LEVEL(AF)) u_dut_s (
    .clk_i(clk), .reset_i(reset), .wr_data_i(s_wr_data), .wr_en_i(s_wr_en),
    .wr_commit_i(s_commit), .wr_discard_i(s_discard), .wr_ready_o(s_wr_ready),
    .drop_o(s_drop), .rd_data_o(s_rd_data), .rd_en_i(s_rd_en), .rd_valid_o(s_rd_valid),
    .level_o(s_level), .almost_full_o(s_af)
  );

  fifo_pkt #(.W(8), .DEPTH_LOG2(4), .PKT_MODE(1), .AF_LEVEL(AF)) u_dut_p (
    .clk_i(clk), .reset_i(reset), .wr_data_i(p_wr_data), .wr_en_i(p_wr_en),
    .wr_commit_i(p_commit), .wr_discard_i(p_discard), .wr_ready_o(p_wr_ready),
    .drop_o(p_drop), .rd_data_o(p_rd_data), .rd_en_i(p_rd_en), .rd_valid_o(p_rd_valid),
    .level_o(p_level), .almost_full_o(p_af)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Models: streaming FIFO is one queue; packet FIFO is committed + pending queues.
  logic [7:0] sq[$];
  logic [7:0] pcq[$];
  logic [7:0] ppq[$];
  bit m_s_drop = 0, m_p_drop = 0, p_dropping = 0;

  initial begin
    bit s_full, p_full;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        sq.delete(); pcq.delete(); ppq.delete();
        m_s_drop = 0; m_p_drop = 0; p_dropping = 0;
      end else begin
        s_full = (sq.size() == DEPTH);
        m_s_drop = 0;
        if (s_rd_en && sq.size() > 0) void'(sq.pop_front());
        if (s_wr_en) begin
          if (s_full) m_s_drop = 1;
          else sq.push_back(s_wr_data);
        end

        p_full = (pcq.size() + ppq.size() == DEPTH);
        m_p_drop = 0;
        if (p_rd_en && pcq.size() > 0) void'(pcq.pop_front());
        if (!p_dropping) begin
          if (p_discard) ppq.delete();
          else if (p_wr_en && p_full) begin
            if (p_commit) begin ppq.delete(); m_p_drop = 1; end
            else p_dropping = 1;
          end else begin
            if (p_wr_en) ppq.push_back(p_wr_data);
            if (p_commit) begin
              foreach (ppq[i]) pcq.push_back(ppq[i]);
              ppq.delete();
            end
          end
        end else if (p_commit || p_discard) begin
          ppq.delete(); m_p_drop = 1; p_dropping = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("s_wr_ready", s_wr_ready, sq.size() < DEPTH);
      chk("s_rd_valid", s_rd_valid, sq.size() > 0);
      chk("s_level", s_level, sq.size());
      chk("s_almost_full", s_af, sq.size() >= AF);
      chk("s_drop", s_drop, m_s_drop);
      if (sq.size() > 0) chk("s_rd_data", s_rd_data, sq[0]);
      chk("p_wr_ready", p_wr_ready, pcq.size() + ppq.size() < DEPTH);
      chk("p_rd_valid", p_rd_valid, pcq.size() > 0);
      chk("p_level", p_level, pcq.size());
      chk("p_almost_full", p_af, pcq.size() + ppq.size() >= AF);
      chk("p_drop", p_drop, m_p_drop);
      if (pcq.size() > 0) chk("p_rd_data", p_rd_data, pcq[0]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_p(input logic [7:0] d, input logic c);
    p_wr_en = 1; p_wr_data = d; p_commit = c;
    cyc();
    p_wr_en = 0; p_commit = 0;
  endtask

  task automatic rd_p(input logic [7:0] d);
    chk("p_read_lit", p_rd_data, d);
    p_rd_en = 1;
    cyc();
    p_rd_en = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pa [3];
    pa[0] = 8'hA1; pa[1] = 8'hA2; pa[2] = 8'hA3;

    #12;
    chk("rst_p_ready", p_wr_ready, 1);
    chk("rst_p_valid", p_rd_valid, 0);
    #10 reset = 0;
    #1;
    chk("rst_s_ready", s_wr_ready, 1);
    chk("rst_s_valid", s_rd_valid, 0);
    chk("rst_s_level", s_level, 0);
    chk("rst_s_drop", s_drop, 0);
    chk("rst_p_af", p_af, 0);
    chk("rst_p_level", p_level, 0);

    // Streaming: fill, overflow, drain.
    for (int i = 0; i < 16; i++) begin
      s_wr_en = 1; s_wr_data = 8'(i);
      cyc();
    end
    chk("s_full_ready", s_wr_ready, 0);
    chk("s_level16", s_level, 16);
    chk("s_af16", s_af, 1);
    s_wr_data = 8'h10;
    cyc();
    s_wr_en = 0;
    chk("s_ovf_drop", s_drop, 1);
    cyc();
    chk("s_drop_once", s_drop, 0);
    for (int i = 0; i < 16; i++) begin
      chk("s_drain_data", s_rd_data, i);
      chk("s_drain_level", s_level, 16 - i);
      s_rd_en = 1;
      cyc();
    end
    s_rd_en = 0;
    chk("s_empty_level", s_level, 0);
    chk("s_empty_valid", s_rd_valid, 0);

    // Streaming: read+write at full, almost_full threshold.
    for (int i = 0; i < 16; i++) begin
      s_wr_en = 1; s_wr_data = 8'(8'h20 + i);
      cyc();
    end
    s_wr_data = 8'h55; s_rd_en = 1;
    cyc();
    s_wr_en = 0; s_rd_en = 0;
    chk("s_dup_level", s_level, 15);
    chk("s_dup_af", s_af, 1);
    chk("s_dup_data", s_rd_data, 8'h21);
    for (int i = 0; i < 3; i++) begin s_rd_en = 1; cyc(); end
    s_rd_en = 0;
    chk("s_af_at12", s_af, 1);
    s_rd_en = 1; cyc(); s_rd_en = 0;
    chk("s_af_at11", s_af, 0);
    chk("s_level11", s_level, 11);
    for (int i = 0; i < 11; i++) begin s_rd_en = 1; cyc(); end
    s_rd_en = 0;

    // Packet: commit on the last write.
    wr_p(pa[0], 0);
    wr_p(pa[1], 0);
    chk("p_not_early", p_rd_valid, 0);
    wr_p(pa[2], 1);
    chk("p_commit_valid", p_rd_valid, 1);
    chk("p_commit_level", p_level, 3);
    for (int i = 0; i < 3; i++) rd_p(pa[i]);

    // Packet: discard rolls back only the pending tail.
    wr_p(8'hB1, 0); wr_p(8'hB2, 1);
    wr_p(8'hC1, 0); wr_p(8'hC2, 0); wr_p(8'hC3, 0);
    p_discard = 1; cyc(); p_discard = 0;
    chk("p_disc_level", p_level, 2);
    chk("p_disc_drop", p_drop, 0);
    wr_p(8'hD1, 1);
    rd_p(8'hB1); rd_p(8'hB2); rd_p(8'hD1);
    chk("p_disc_empty", p_rd_valid, 0);

    // Packet: oversize packet dropped on commit.
    for (int i = 0; i < 20; i++) begin
      p_wr_en = 1; p_wr_data = 8'(8'h40 + i);
      cyc();
    end
    p_wr_en = 0;
    chk("p_big_full", p_wr_ready, 0);
    chk("p_big_level", p_level, 0);
    p_commit = 1; cyc(); p_commit = 0;
    chk("p_big_drop", p_drop, 1);
    chk("p_big_level0", p_level, 0);
    chk("p_big_ready", p_wr_ready, 1);
    cyc();
    chk("p_big_drop_once", p_drop, 0);
    for (int i = 0; i < 4; i++) wr_p(8'(8'hE0 + i), i == 3);
    for (int i = 0; i < 4; i++) rd_p(8'(8'hE0 + i));

    // Packet: overflow on the committing beat.
    for (int i = 0; i < 16; i++) wr_p(8'(i), 0);
    wr_p(8'h99, 1);
    chk("p_ovc_drop", p_drop, 1);
    chk("p_ovc_level", p_level, 0);
    chk("p_ovc_ready", p_wr_ready, 1);
    wr_p(8'hF0, 1);
    rd_p(8'hF0);

    // Asynchronous reset mid-packet.
    for (int i = 0; i < 5; i++) wr_p(8'(8'h60 + i), i == 4);
    for (int i = 0; i < 3; i++) wr_p(8'(8'h70 + i), 0);
    s_wr_en = 1; s_wr_data = 8'h77; cyc(); s_wr_en = 0;
    chk("p_prerst_level", p_level, 5);
    #2 reset = 1;
    #1;
    chk("arst_p_valid", p_rd_valid, 0);
    chk("arst_p_level", p_level, 0);
    chk("arst_p_ready", p_wr_ready, 1);
    chk("arst_s_level", s_level, 0);
    @(posedge clk);
    #3 reset = 0;
    cyc(); cyc();
    chk("arst_no_drop", p_drop, 0);
    chk("arst_level", p_level, 0);

    // Randomised traffic with varying read pressure.
    for (int c = 0; c < 4000; c++) begin
      int rdp;
      rdp = ((c / 400) % 2 == 0) ? 25 : 80;
      s_wr_en   = ($urandom_range(0, 99) < 60);
      s_wr_data = 8'($urandom);
      s_rd_en   = ($urandom_range(0, 99) < rdp);
      s_commit  = ($urandom_range(0, 99) < 10);
      s_discard = ($urandom_range(0, 99) < 5);
      p_wr_en   = ($urandom_range(0, 99) < 65);
      p_wr_data = 8'($urandom);
      p_rd_en   = ($urandom_range(0, 99) < rdp);
      p_commit  = ($urandom_range(0, 99) < 12);
      p_discard = ($urandom_range(0, 99) < 4);
      cyc();
    end
    s_wr_en = 0; s_rd_en = 0; s_commit = 0; s_discard = 0;
    p_wr_en = 0; p_rd_en = 0; p_commit = 0; p_discard = 0;
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
